ddr_axi_wr_burst: RTL

- Upstream write stage for the DDR3 controller's AXI-style write port.
- Accepts a 256-bit word stream (valid/ready) into a local FIFO.
- Once a full burst is buffered, issues one fixed-length write burst (axi_awaddr/awlen, then wdata on wready) at linearly incrementing addresses inside a configurable ring region.
- Runs in the controller's core_clk domain; one burst outstanding at a time.

---
 rtl/ddr_axi_wr_burst.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ddr_axi_wr_burst.sv
// Upstream write stage: buffers a 256-bit stream in a FWFT FIFO and issues
// fixed-length AXI-style write bursts at ring-wrapped incrementing addresses.
module ddr_axi_wr_burst #(
   parameter int unsigned CTRL_ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH      = 256,
   parameter int unsigned BURST_LEN       = 16,
   parameter int unsigned FIFO_DEPTH      = 64,
   parameter logic [3:0]  AXI_ID          = 4'd0
) (
   input  logic                            core_clk,
   input  logic                            core_rst,
   input  logic                            ddr_init_done,
   input  logic                            cfg_enable,
   input  logic [CTRL_ADDR_WIDTH-1:0]      cfg_base_addr,
   input  logic [15:0]                     cfg_num_bursts,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [DATA_WIDTH-1:0]           s_data,
   output logic [CTRL_ADDR_WIDTH-1:0]      axi_awaddr,
   output logic                            axi_awuser_ap,
   output logic [3:0]                      axi_awuser_id,
   output logic [3:0]                      axi_awlen,
   output logic                            axi_awvalid,
   input  logic                            axi_awready,
   output logic [DATA_WIDTH-1:0]           axi_wdata,
   output logic [DATA_WIDTH/8-1:0]         axi_wstrb,
   input  logic                            axi_wready,
   input  logic                            axi_wusero_last,
   output logic                            burst_done,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            err_last
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [4:0]                 LAST_BEAT = 5'(BURST_LEN - 1);
   localparam logic [LVL_W-1:0]           FULL_LVL  = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]           BURST_LVL = LVL_W'(BURST_LEN);
   localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_STEP = CTRL_ADDR_WIDTH'(BURST_LEN * 8);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA
   } state_t;

   state_t                       state_q, state_d;
   logic [4:0]                   beat_q, beat_d;
   logic [CTRL_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]                  idx_q, idx_d;
   logic [15:0]                  idx_next;
   logic                         done_q, done_d;
   logic                         err_q, err_d;
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]             level_q, level_d;
   logic [DATA_WIDTH-1:0]        mem_q [FIFO_DEPTH];

   logic push;
   logic pop;
   logic last_beat;

   // s_ready is forced low while reset is held so nothing is pushed during a flush
   assign s_ready   = !core_rst && (level_q != FULL_LVL);
   assign push      = s_valid && s_ready;
   assign pop       = (state_q == ST_DATA) && axi_wready;
   assign last_beat = (beat_q == LAST_BEAT);

   assign axi_awaddr    = addr_q;
   assign axi_awuser_ap = 1'b0;
   assign axi_awuser_id = AXI_ID;
   assign axi_awlen     = 4'(BURST_LEN - 1);
   assign axi_awvalid   = (state_q == ST_ADDR);
   assign axi_wdata     = mem_q[rd_ptr_q];
   assign axi_wstrb     = '1;
   assign burst_done    = done_q;
   assign fifo_level    = level_q;
   assign err_last      = err_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      addr_d   = addr_q;
      idx_d    = idx_q;
      idx_next = idx_q + 16'd1;
      done_d   = 1'b0;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_enable && ddr_init_done && (level_q >= BURST_LVL)) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (axi_awready) begin
               state_d = ST_DATA;
               beat_d  = '0;
            end
         end
         ST_DATA: begin
            if (axi_wready) begin
               if (axi_wusero_last != last_beat) err_d = 1'b1;
               if (last_beat) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  // ring wrap reloads the live base so config changes land here
                  if ((cfg_num_bursts != '0) && (idx_next >= cfg_num_bursts)) begin
                     idx_d  = '0;
                     addr_d = cfg_base_addr;
                  end else begin
                     idx_d  = idx_next;
                     addr_d = addr_q + ADDR_STEP;
                  end
               end else begin
                  beat_d = beat_q + 5'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q  <= ST_IDLE;
         beat_q   <= '0;
         addr_q   <= cfg_base_addr;
         idx_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         addr_q   <= addr_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge core_clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

endmodule
